counter_step_controller: RTL
============================

Name: counter_step_controller

Overview:
- Sequencer in front of the MonitorVGA 6-bit up/down step counter (enable/forward/increment/finish interface).
- Turns manual up/down requests and an optional auto-run timer into clean step transactions.
- Each transaction holds forward stable one cycle before and one cycle after a single-cycle increment pulse.
- Arbitrates between requesters and latches the counter's finish indication.

Parameters:
- PERIOD, 16, auto-run step interval in clock cycles; legal range 4..255.
- TW, 8, auto-run timer width in bits; must satisfy 2^TW > PERIOD.

Ports:
- clk  in  1  system clock; all logic rises on posedge clk.
- reset  in  1  synchronous, active-high reset.
- up_req  in  1  level request, already synchronized; each 0->1 transition requests one forward step.
- down_req  in  1  level request, already synchronized; each 0->1 transition requests one backward step.
- auto_en  in  1  level; while high, a forward step is requested every PERIOD cycles.
- clear  in  1  single-cycle pulse; clears done.
- cnt_finish  in  1  finish output of the step counter.
- cnt_enable  out  1  enable to the counter.
- cnt_forward  out  1  direction to the counter; 1 = up.
- cnt_increment  out  1  step pulse to the counter.
- busy  out  1  high while a step transaction is in progress.
- done  out  1  sticky flag, set when cnt_finish is seen.

Behaviour:
Cycle convention:
- "Cycle k" is the interval after posedge k.
- All outputs are registered.

Reset:
- State = IDLE.
- Outputs 0: cnt_enable, cnt_forward, cnt_increment, busy, done.
- Pending flags = 0; auto timer = 0.
- Edge-detect history registers load the current up_req/down_req values during reset, so a request held across reset release is not treated as an edge.
- cnt_enable = 1 from the first cycle after reset deasserts.

Reset mid-operation:
- Aborts any transaction; cnt_increment is 0 in the next cycle.
- Pending requests are discarded.

Edge detect and pending flags:
- up_pend is set at edge k when up_req = 1 at k and 0 at k-1; down_pend likewise for down_req.
- One pending slot per source: a further edge while that source's flag is already set is dropped.
- Edges arriving while busy are latched and served after the current transaction.

Auto timer:
- Counts while auto_en = 1 and done = 0; otherwise held at 0 and auto_pend is cleared.
- On reaching PERIOD-1 it wraps to 0 and sets auto_pend.
- An expiry while auto_pend is already set is dropped; no accumulation.

Arbitration (evaluated only in IDLE), in order:
1. up_pend and down_pend both set: both cleared, no step (net zero); auto_pend is not granted that cycle.
2. up_pend: forward step.
3. down_pend: backward step.
4. auto_pend: forward step.
- The granted flag clears on the grant edge.

FSM (advances every cycle, enable-independent):
- IDLE: busy = 0, cnt_increment = 0, cnt_forward holds its last value. On grant -> SETUP.
- SETUP: cnt_forward = granted direction, busy = 1 -> PULSE.
- PULSE: cnt_increment = 1 for exactly one cycle, cnt_forward held -> RELEASE.
- RELEASE: cnt_increment = 0, cnt_forward held -> IDLE.

Latency and throughput:
- Edge sampled at k: pending flag high in cycle k, SETUP in k+1, PULSE in k+2, RELEASE in k+3, IDLE in k+4.
- Minimum 4 cycles per step; a queued request enters SETUP in cycle k+5.

done:
- Set at any edge where cnt_finish = 1; stays set.
- clear at an edge where cnt_finish = 0 clears it.
- If clear and cnt_finish coincide, done stays 1.
- While done = 1, auto-run is suppressed; manual steps are still served.

Test Plan:
1. Reset held 3 cycles with up_req = 1, then released and up_req kept high -> no step; cnt_enable goes 1 the cycle after release; all other outputs remain 0.
2. Single up_req pulse sampled at edge 10 -> cnt_forward = 1 from cycle 11; cnt_increment = 1 in cycle 12 only; busy = 1 in cycles 11-13; IDLE in cycle 14.
3. down_req edge at 20 and up_req edge at 21 (busy) -> backward pulse in cycle 22; up served with SETUP in cycle 25 and pulse in cycle 26; cnt_forward changes 0->1 only in cycle 25.
4. up_req and down_req rise at the same edge -> no cnt_increment pulse; both pending flags clear.
5. auto_en = 1, PERIOD = 16, from cycle 0 -> forward pulses 16 cycles apart; a manual down edge coinciding with an auto expiry is served first and the auto step follows 4 cycles later.
6. cnt_finish = 1 during auto-run -> done = 1 the next cycle and no further auto pulses; clear pulse with cnt_finish = 0 -> done = 0 and auto pulses resume after PERIOD cycles; clear coincident with cnt_finish = 1 -> done stays 1.

Source files
------------

// File: rtl/counter_step_controller.sv
// rtl/counter_step_controller.sv - step sequencer for a 6-bit up/down counter.
// Turns up/down request edges and an auto-run timer into setup/pulse/release step transactions.
module counter_step_controller #(
  parameter int PERIOD = 16,
  parameter int TW     = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic up_req,
  input  logic down_req,
  input  logic auto_en,
  input  logic clear,
  input  logic cnt_finish,
  output logic cnt_enable,
  output logic cnt_forward,
  output logic cnt_increment,
  output logic busy,
  output logic done
);

  typedef enum logic [1:0] {IDLE, SETUP, PULSE, RELEASE} state_t;

  state_t        state_q, state_d;
  logic          up_hist_q, down_hist_q;
  logic          up_pend_q, up_pend_d;
  logic          down_pend_q, down_pend_d;
  logic          auto_pend_q, auto_pend_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          cnt_enable_q;
  logic          cnt_forward_q, cnt_forward_d;
  logic          cnt_increment_q, cnt_increment_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic up_edge, down_edge, auto_run, expire, idle;
  logic cancel, grant_up, grant_down, grant_auto;

  always_comb begin
    up_edge    = up_req & ~up_hist_q;
    down_edge  = down_req & ~down_hist_q;
    auto_run   = auto_en & ~done_q;
    expire     = auto_run && (timer_q == TW'(PERIOD - 1));
    idle       = (state_q == IDLE);
    // Simultaneous up and down requests cancel out and block auto for that cycle.
    cancel     = idle & up_pend_q & down_pend_q;
    grant_up   = idle & up_pend_q & ~down_pend_q;
    grant_down = idle & down_pend_q & ~up_pend_q;
    grant_auto = idle & auto_pend_q & ~up_pend_q & ~down_pend_q;

    up_pend_d   = up_pend_q ? ~(grant_up | cancel) : up_edge;
    down_pend_d = down_pend_q ? ~(grant_down | cancel) : down_edge;
    auto_pend_d = auto_run & (auto_pend_q ? ~grant_auto : expire);
    timer_d     = (!auto_run || expire) ? '0 : timer_q + TW'(1);
    done_d      = cnt_finish | (done_q & ~clear);

    state_d         = state_q;
    cnt_forward_d   = cnt_forward_q;
    cnt_increment_d = 1'b0;
    busy_d          = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_up || grant_down || grant_auto) begin
          state_d       = SETUP;
          cnt_forward_d = ~grant_down;
          busy_d        = 1'b1;
        end
      end
      SETUP: begin
        state_d         = PULSE;
        cnt_increment_d = 1'b1;
        busy_d          = 1'b1;
      end
      PULSE: begin
        state_d = RELEASE;
        busy_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      up_hist_q       <= up_req;
      down_hist_q     <= down_req;
      up_pend_q       <= 1'b0;
      down_pend_q     <= 1'b0;
      auto_pend_q     <= 1'b0;
      timer_q         <= '0;
      cnt_enable_q    <= 1'b0;
      cnt_forward_q   <= 1'b0;
      cnt_increment_q <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      up_hist_q       <= up_req;
      down_hist_q     <= down_req;
      up_pend_q       <= up_pend_d;
      down_pend_q     <= down_pend_d;
      auto_pend_q     <= auto_pend_d;
      timer_q         <= timer_d;
      cnt_enable_q    <= 1'b1;
      cnt_forward_q   <= cnt_forward_d;
      cnt_increment_q <= cnt_increment_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
    end
  end

  assign cnt_enable    = cnt_enable_q;
  assign cnt_forward   = cnt_forward_q;
  assign cnt_increment = cnt_increment_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule
